ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, usable in the same cycle.
- Adds per-byte write masks and a selectable read-during-write policy.
- Adds a hardware clear sequencer that fills memory with CLEAR_VALUE after reset and on request.
- Successor to the single-port 8-bit RAM; serves as the general storage block for register files, scratchpads and the next CPU datapath.

Parameters:
- ADDR_WIDTH, 8, address bits on both ports.
- DATA_WIDTH, 16, word width; must be a multiple of 8.
- DEPTH, 2**ADDR_WIDTH, implemented words; must be <= 2**ADDR_WIDTH.
- RDW_MODE, 0, same-address read-during-write policy: 0 = return old data, 1 = return new (merged) data.
- CLEAR_VALUE, 0, word written to every location by the clear sequencer.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_we  in  1  write enable.
- i_waddr  in  ADDR_WIDTH  write address.
- i_wdata  in  DATA_WIDTH  write data.
- i_wmask  in  DATA_WIDTH/8  byte enables; bit k covers wdata[8k+7:8k].
- i_re  in  1  read enable.
- i_raddr  in  ADDR_WIDTH  read address.
- or_rdata  out  DATA_WIDTH  registered read data.
- or_rvalid  out  1  registered; high the cycle or_rdata carries a fresh read.
- i_clear  in  1  request full-memory clear.
- o_busy  out  1  high while clear sequencer runs; combinational from state.

Behaviour:
- Reset (async assert): or_rdata=0, or_rvalid=0, FSM=CLEAR, clear counter=0, o_busy=1. Memory array is not reset asynchronously.
- FSM states:
  - CLEAR: each cycle writes CLEAR_VALUE (all bytes) at the counter, then increments the counter. After writing DEPTH-1, go to IDLE. o_busy falls exactly DEPTH cycles after reset release.
  - IDLE: normal operation. i_clear=1 at an edge loads counter=0 and enters CLEAR next cycle. The user write/read in that same cycle are still performed.
- While in CLEAR:
  - i_we, i_re and i_clear are ignored.
  - or_rvalid=0 and or_rdata holds its value.
- Write (IDLE, i_we=1, i_waddr<DEPTH): bytes with mask bit set are updated at the edge; others are unchanged. i_wmask=0 means no change. i_waddr>=DEPTH: write dropped.
- Read (IDLE, i_re=1): latency 1. or_rdata = mem[i_raddr] after the edge; or_rvalid=1 for that cycle. i_raddr>=DEPTH returns 0 with or_rvalid=1.
- i_re=0: or_rdata holds its last value; or_rvalid=0.
- Same-address read and write in one cycle:
  - RDW_MODE=0: or_rdata = pre-write contents.
  - RDW_MODE=1: or_rdata = merge of new masked bytes and old unmasked bytes.
  - Different addresses: independent.
- Reset asserted mid-clear or mid-operation: immediate return to reset state. The clear restarts from address 0 after release.
- Counter is wide enough for DEPTH-1 with no wrap.
- No X may propagate to or_rdata after the first clear completes.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=12, CLEAR_VALUE=16'hA5A5):
1. Release reset, hold i_re=1, i_raddr=5 throughout:
   - o_busy=1 for exactly 12 cycles, then 0.
   - or_rvalid stays 0 until the first IDLE read, which returns 16'hA5A5.
2. Write 16'h1234 to addr 3 with mask 2'b11; next cycle read addr 3 -> or_rdata=16'h1234, or_rvalid=1 one cycle later. Then write 16'hFFFF with mask 2'b01, read -> 16'h12FF.
3. Addr 3 holds 16'h12FF; write 16'hBEEF (mask 2'b11) and read addr 3 in the same cycle:
   - RDW_MODE=0 -> or_rdata=16'h12FF, a following read -> 16'hBEEF.
   - RDW_MODE=1 -> 16'hBEEF immediately.
4. Write addr 14 (>=DEPTH) with 16'h7777, then read addr 14 -> 16'h0000 with or_rvalid=1; addr 2 (16'hA5A5 from the clear) unaffected.
5. Fill addrs 0..11 with addr*16'h0101. Pulse i_clear:
   - o_busy=1 for 12 cycles.
   - A write to addr 4 issued during busy is ignored.
   - Afterwards all 12 addresses read 16'hA5A5.
6. Assert i_rst_n=0 at counter=6 of a clear: outputs zero asynchronously. After release, a full 12-cycle clear reruns and all addresses read 16'hA5A5.

Source files
------------

// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dp_clr
//  Description : Simple-dual-port synchronous RAM (one write port, one read
//                port) with per-byte write masks, selectable same-address
//                read-during-write policy and a hardware clear sequencer
//                that fills every word with CLEAR_VALUE after reset and on
//                request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_clr #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    DEPTH       = 2**ADDR_WIDTH,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wmask,
    input  logic                    i_re,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   or_rdata,
    output logic                    or_rvalid,
    input  logic                    i_clear,
    output logic                    o_busy
);

    localparam int                  c_NBYTES  = DATA_WIDTH / 8;
    // Depth expressed one bit wider than an address so that the range check
    // also works when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Parameter sanity checks (elaboration time only)
    // ------------------------------------------------------------------
    if (DATA_WIDTH % 8 != 0) begin : g_chk_data_width
        $error("ram_dp_clr: DATA_WIDTH must be a multiple of 8");
    end
    if ((DEPTH < 1) || (DEPTH > 2**ADDR_WIDTH)) begin : g_chk_depth
        $error("ram_dp_clr: DEPTH must be in 1 .. 2**ADDR_WIDTH");
    end

    // ------------------------------------------------------------------
    // Clear sequencer state
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    // The counter never exceeds DEPTH-1, which always fits an address.
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0]  w_cnt_nxt;

    // Storage array; deliberately not reset, the clear sequencer covers it.
    logic [DATA_WIDTH-1:0]  r_mem [0:DEPTH-1];

    // Write/read qualification
    logic                   w_idle;
    logic                   w_waddr_ok;
    logic                   w_raddr_ok;
    logic                   w_collide;
    logic [DATA_WIDTH-1:0]  w_merged;
    logic [DATA_WIDTH-1:0]  w_rd_next;

    // Shared memory write port, muxed between the sequencer and the user
    logic                   w_mem_we;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0]  w_mem_wdata;
    logic [c_NBYTES-1:0]    w_mem_be;

    assign w_idle     = (r_state == S_IDLE);
    assign w_waddr_ok = ({1'b0, i_waddr} < c_DEPTH_X);
    assign w_raddr_ok = ({1'b0, i_raddr} < c_DEPTH_X);
    assign w_collide  = i_we && w_waddr_ok && (i_waddr == i_raddr);
    assign o_busy     = (r_state == S_CLEAR);

    // State and counter registers; reset restarts the clear from address 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: walk the counter through 0..DEPTH-1, then go idle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Memory write-port mux: sequencer writes whole words, user writes bytes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = i_waddr;
        w_mem_wdata = i_wdata;
        w_mem_be    = i_wmask;
        if (r_state == S_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = CLEAR_VALUE;
            w_mem_be    = '1;
        end else if (i_we && w_waddr_ok) begin
            w_mem_we    = 1'b1;
        end
    end

    // Byte-masked array write
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < c_NBYTES; k++) begin
                if (w_mem_be[k]) begin
                    r_mem[w_mem_addr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Word as it will look after this cycle's user write (new-data mode)
    always_comb begin
        w_merged = r_mem[i_waddr];
        for (int k = 0; k < c_NBYTES; k++) begin
            if (i_wmask[k]) begin
                w_merged[8*k +: 8] = i_wdata[8*k +: 8];
            end
        end
    end

    // Read data selection: out-of-range reads return zero
    always_comb begin
        w_rd_next = '0;
        if (w_raddr_ok) begin
            if ((RDW_MODE != 0) && w_collide) begin
                w_rd_next = w_merged;
            end else begin
                w_rd_next = r_mem[i_raddr];
            end
        end
    end

    // Registered read port; data holds when no read is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            or_rdata  <= '0;
            or_rvalid <= 1'b0;
        end else if (w_idle && i_re) begin
            or_rdata  <= w_rd_next;
            or_rvalid <= 1'b1;
        end else begin
            or_rvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dp_clr
//  Description : Self-checking bench for ram_dp_clr (old-data and new-data
//                read-during-write instances driven in parallel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_clr;

    localparam int          c_AW    = 4;
    localparam int          c_DW    = 16;
    localparam int          c_DEPTH = 12;
    localparam logic [15:0] c_CLR   = 16'hA5A5;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        re;
    logic [3:0]  raddr;
    logic        clear;
    logic [15:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_mem [c_DEPTH];
    logic [15:0] m_rd0, m_rd1;
    logic        m_rv;
    int          m_busy;

    ram_dp_clr #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH),
                 .RDW_MODE(0), .CLEAR_VALUE(c_CLR)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr),
        .i_wdata(wdata), .i_wmask(wmask), .i_re(re), .i_raddr(raddr),
        .or_rdata(rdata0), .or_rvalid(rvalid0), .i_clear(clear), .o_busy(busy0));

    ram_dp_clr #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH),
                 .RDW_MODE(1), .CLEAR_VALUE(c_CLR)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr),
        .i_wdata(wdata), .i_wmask(wmask), .i_re(re), .i_raddr(raddr),
        .or_rdata(rdata1), .or_rvalid(rvalid1), .i_clear(clear), .o_busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] m);
        merge = old;
        if (m[0]) merge[7:0]  = nw[7:0];
        if (m[1]) merge[15:8] = nw[15:8];
    endfunction

    task automatic model_fill();
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = c_CLR;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rdata0"},  {16'h0, rdata0}, {16'h0, m_rd0});
        chk({tag, "_rdata1"},  {16'h0, rdata1}, {16'h0, m_rd1});
        chk({tag, "_rvalid0"}, {31'h0, rvalid0}, {31'h0, m_rv});
        chk({tag, "_rvalid1"}, {31'h0, rvalid1}, {31'h0, m_rv});
        chk({tag, "_busy0"},   {31'h0, busy0}, {31'h0, (m_busy > 0)});
        chk({tag, "_busy1"},   {31'h0, busy1}, {31'h0, (m_busy > 0)});
    endtask

    // Asynchronous reset: the model returns to "clear pending" with the
    // memory ending up all CLEAR_VALUE once the clear completes.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        m_rd0 = '0; m_rd1 = '0; m_rv = 1'b0; m_busy = c_DEPTH;
        model_fill();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cycle(input string tag, input logic w, input logic [3:0] wa,
                         input logic [15:0] wd, input logic [1:0] wm,
                         input logic r, input logic [3:0] ra, input logic c);
        we = w; waddr = wa; wdata = wd; wmask = wm; re = r; raddr = ra; clear = c;
        if (m_busy > 0) begin
            m_rv = 1'b0;
            m_busy--;
        end else begin
            if (r) begin
                m_rv = 1'b1;
                if (ra < c_DEPTH) begin
                    m_rd0 = m_mem[ra];
                    m_rd1 = (w && wa == ra) ? merge(m_mem[ra], wd, wm) : m_mem[ra];
                end else begin
                    m_rd0 = '0;
                    m_rd1 = '0;
                end
            end else begin
                m_rv = 1'b0;
            end
            if (w && wa < c_DEPTH) m_mem[wa] = merge(m_mem[wa], wd, wm);
            if (c) begin
                model_fill();
                m_busy = c_DEPTH;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [3:0] a);
        cycle(tag, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] m);
        cycle(tag, 1'b1, a, d, m, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; we = 0; waddr = 0; wdata = 0; wmask = 0;
        re = 0; raddr = 0; clear = 0;
        #1;
        apply_reset("reset");

        // 1: clear after reset, reading address 5 throughout
        for (int i = 0; i < c_DEPTH; i++) rd("t1_busy", 4'd5);
        chk("t1_busy_fell", {31'h0, busy0}, 32'h0);
        chk("t1_no_valid_yet", {31'h0, rvalid0}, 32'h0);
        rd("t1_first_read", 4'd5);
        chk("t1_rd_a5a5", {16'h0, rdata0}, 32'h0000_A5A5);

        // 2: full write then byte-masked write
        wr("t2_wr", 4'd3, 16'h1234, 2'b11);
        rd("t2_rd", 4'd3);
        chk("t2_rd_1234", {16'h0, rdata0}, 32'h0000_1234);
        wr("t2_wr_lo", 4'd3, 16'hFFFF, 2'b01);
        rd("t2_rd_lo", 4'd3);
        chk("t2_rd_12ff", {16'h0, rdata0}, 32'h0000_12FF);

        // 3: same-address read during write
        cycle("t3_rdw", 1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b1, 4'd3, 1'b0);
        chk("t3_old_data", {16'h0, rdata0}, 32'h0000_12FF);
        chk("t3_new_data", {16'h0, rdata1}, 32'h0000_BEEF);
        rd("t3_after", 4'd3);
        chk("t3_after_beef", {16'h0, rdata0}, 32'h0000_BEEF);

        // 4: out-of-range write and read
        wr("t4_wr_oob", 4'd14, 16'h7777, 2'b11);
        rd("t4_rd_oob", 4'd14);
        chk("t4_oob_zero", {16'h0, rdata0}, 32'h0);
        chk("t4_oob_valid", {31'h0, rvalid0}, 32'h1);
        rd("t4_rd2", 4'd2);
        chk("t4_addr2", {16'h0, rdata0}, 32'h0000_A5A5);

        // 5: fill, clear on request, write during busy ignored
        for (int a = 0; a < c_DEPTH; a++)
            wr("t5_fill", 4'(a), 16'(a) * 16'h0101, 2'b11);
        rd("t5_rd7", 4'd7);
        chk("t5_fill7", {16'h0, rdata0}, 32'h0000_0707);
        cycle("t5_clear", 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < c_DEPTH; i++) begin
            if (i == 3) wr("t5_busy_wr", 4'd4, 16'h4444, 2'b11);
            else        idle("t5_busy");
        end
        for (int a = 0; a < c_DEPTH; a++) rd("t5_rdback", 4'(a));
        rd("t5_rd4", 4'd4);
        chk("t5_addr4_cleared", {16'h0, rdata0}, 32'h0000_A5A5);

        // 6: reset in the middle of a clear
        wr("t6_wr", 4'd9, 16'h9999, 2'b11);
        cycle("t6_clear", 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) idle("t6_busy");
        apply_reset("t6_reset");
        chk("t6_rdata_zero", {16'h0, rdata0}, 32'h0);
        for (int i = 0; i < c_DEPTH; i++) idle("t6_reclear");
        chk("t6_busy_fell", {31'h0, busy0}, 32'h0);
        for (int a = 0; a < c_DEPTH; a++) rd("t6_rdback", 4'(a));

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
